addsub_seq: RTL and testbench
=============================

ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter DIGIT, default 4, bits processed per clock cycle; WIDTH SHALL be an integer multiple of DIGIT, else elaboration error.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request; sampled only while busy=0.
REQ-006 setup  input  1  mode: 1 = add, 0 = subtract.
REQ-007 a, b  input  WIDTH  operands, unsigned or two's-complement.
REQ-008 ci  input  1  carry-in (add) / borrow-in (subtract).
REQ-009 s  output  WIDTH  registered result.
REQ-010 co  output  1  carry-out (add) / borrow-out (subtract), registered.
REQ-011 ov  output  1  signed two's-complement overflow, registered.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  one-cycle pulse marking s/co/ov valid.

Function
REQ-014 Add SHALL compute s = a + b + ci, co = carry out of bit WIDTH-1.
REQ-015 Subtract SHALL compute s = a - b - ci modulo 2^WIDTH, co = 1 when a < b + ci (unsigned borrow).
REQ-016 Subtract SHALL be implemented as a + ~b with internal carry seeded to ~ci; co = inverted final carry.
REQ-017 ov SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 of the internal addition, both modes.
REQ-018 FSM states: IDLE, RUN; N = WIDTH/DIGIT.
REQ-019 IDLE -> RUN when start=1 at an edge; that edge latches a, b, ci, setup and clears the digit counter; busy rises.
REQ-020 In RUN, each edge processes one DIGIT-bit slice, LSB slice first, propagating a 1-bit carry register between slices.
REQ-021 After the N-th slice edge: FSM -> IDLE, busy=0, s/co/ov updated, done=1 for exactly that following cycle.
REQ-022 Latency: start sampled at edge 0 -> done high in the cycle after edge N; busy high from edge 0 to edge N.
REQ-023 s/co/ov SHALL hold their values until the next operation completes; they SHALL NOT change during RUN.
REQ-024 start while busy=1 SHALL be ignored; operand changes during RUN SHALL have no effect.
REQ-025 start=1 in the done cycle SHALL be accepted (back-to-back, one operation per N+0 idle cycles).
REQ-026 DIGIT=WIDTH SHALL give N=1: done the cycle after start.

Reset
REQ-027 rst_n=0 at an edge: FSM=IDLE, s=0, co=0, ov=0, busy=0, done=0, counter and carry register cleared.
REQ-028 Reset during RUN SHALL abort the operation; no done pulse SHALL follow for it.

Structure
REQ-029 Package addsub_pkg SHALL hold the state enum (IDLE, RUN) and mode constants MODE_ADD=1, MODE_SUB=0.
REQ-030 One sub-module addsub_digit (combinational DIGIT-bit slice: a, b, carry-in, mode -> sum, carry-out, carry into slice MSB) SHALL be instantiated once.

Verification
REQ-031 WIDTH=16, DIGIT=4: add 0x1234+0x0FFF ci=0 -> s=0x2233, co=0, ov=0, done 4 cycles after start edge's next cycle.
REQ-032 Sub 0x0005-0x0007 ci=0 -> s=0xFFFE, co=1, ov=0; sub 0x8000-0x0001 -> s=0x7FFF, co=0, ov=1.
REQ-033 Add 0x7FFF+0x0001 ci=0 -> s=0x8000, co=0, ov=1; add 0xFFFF+0x0000 ci=1 -> s=0x0000, co=1, ov=0.
REQ-034 start pulsed at RUN cycle 2 with new operands -> ignored, result of first op; start held in done cycle -> second op accepted, done again 4 cycles later.
REQ-035 rst_n=0 during RUN cycle 2 -> next edge busy=0, s=0, co=0, no done for 10 cycles.
REQ-036 WIDTH=DIGIT=4: exhaustive a, b, ci, setup (1024 cases) vs behavioural model, done 1 cycle after each start.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
// Contents:
//   state_t        - controller states (IDLE, RUN)
//   MODE_ADD/SUB   - encodings of the setup input
//   seed_carry     - internal carry-in for the first slice
//   final_carry    - maps the internal carry-out to the reported carry/borrow
package addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  // Subtraction is a + ~b + 1 - borrow_in, so the internal carry is seeded with ~ci.
  function automatic logic seed_carry(input logic mode, input logic ci);
    seed_carry = (mode == MODE_ADD) ? ci : ~ci;
  endfunction

  // A borrow out of a subtraction is the inverse of the internal carry out.
  function automatic logic final_carry(input logic mode, input logic carry);
    final_carry = (mode == MODE_ADD) ? carry : ~carry;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice of the adder/subtractor.
// Ports:
//   a, b  - operand slices (b is inverted internally in subtract mode)
//   cin   - internal carry into the slice LSB
//   mode  - MODE_ADD / MODE_SUB
//   sum   - slice sum
//   cout  - carry out of the slice MSB
//   cmsb  - carry into the slice MSB (used for signed overflow on the top slice)
module addsub_digit
  import addsub_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT-1:0] b_eff_s;
  logic [DIGIT:0]   carry_s;

  // Bitwise ripple so the carry into the MSB is directly available.
  always_comb begin
    b_eff_s    = (mode == MODE_SUB) ? ~b : b;
    carry_s    = {(DIGIT+1){1'b0}};
    sum        = {DIGIT{1'b0}};
    carry_s[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]       = a[i] ^ b_eff_s[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b_eff_s[i]) | (a[i] & carry_s[i]) | (b_eff_s[i] & carry_s[i]);
    end
    cout = carry_s[DIGIT];
    cmsb = carry_s[DIGIT-1];
  end

endmodule

// File: rtl/addsub_seq.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB slice first.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - operation request, sampled only while idle
//   setup  - 1 = add, 0 = subtract
//   a, b   - operands (WIDTH bits)
//   ci     - carry-in (add) / borrow-in (subtract)
//   s      - registered result, held until the next operation completes
//   co     - registered carry-out (add) / borrow-out (subtract)
//   ov     - registered signed overflow
//   busy   - operation in progress
//   done   - one-cycle pulse when s/co/ov are refreshed
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             setup,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("addsub_seq: WIDTH must be a positive integer multiple of DIGIT");
  end

  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic                mode_r;
  logic                carry_r;

  logic [DIGIT-1:0]       sum_s;
  logic                   cout_s;
  logic                   cmsb_s;
  logic [WIDTH+DIGIT-1:0] cat_s;
  logic [WIDTH-1:0]       a_next_s;

  addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a    (a_r[DIGIT-1:0]),
    .b    (b_r[DIGIT-1:0]),
    .cin  (carry_r),
    .mode (mode_r),
    .sum  (sum_s),
    .cout (cout_s),
    .cmsb (cmsb_s)
  );

  // a_r doubles as the result accumulator: each slice shifts the consumed
  // operand bits out at the bottom and the new sum digit in at the top, so
  // after N slices it holds the full result.
  always_comb begin
    cat_s    = {sum_s, a_r};
    a_next_s = cat_s[WIDTH+DIGIT-1:DIGIT];
  end

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      mode_r  <= 1'b0;
      carry_r <= 1'b0;
      s       <= {WIDTH{1'b0}};
      co      <= 1'b0;
      ov      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            mode_r  <= setup;
            carry_r <= seed_carry(setup, ci);
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          a_r     <= a_next_s;
          b_r     <= b_r >> DIGIT;
          carry_r <= cout_s;
          if (cnt_r == LAST) begin
            // Top slice: publish the result and return to idle.
            s       <= a_next_s;
            co      <= final_carry(mode_r, cout_s);
            ov      <= cmsb_s ^ cout_s;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: a 16/4 instance and a 4/4 instance, each checked
// every cycle against an arithmetic reference model, plus literal checks.
module tb_addsub_seq;

  logic clk;
  logic rst_n;

  logic        start16, setup16, ci16;
  logic [15:0] a16, b16, s16;
  logic        co16, ov16, busy16, done16;

  logic        start4, setup4, ci4;
  logic [3:0]  a4, b4, s4;
  logic        co4, ov4, busy4, done4;

  int n_checks;
  int n_pass;
  logic chk_en;

  addsub_seq #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .setup(setup16), .a(a16), .b(b16),
    .ci(ci16), .s(s16), .co(co16), .ov(ov16), .busy(busy16), .done(done16)
  );

  addsub_seq #(.WIDTH(4), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .setup(setup4), .a(a4), .b(b4),
    .ci(ci4), .s(s4), .co(co4), .ov(ov4), .busy(busy4), .done(done4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference result {ov, co, s} from plain integer arithmetic.
  function automatic logic [17:0] model_res(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic ci, input logic setup);
    longint one, mask, half, ua, ub, sa, sb, full, sg;
    logic co, ov;
    logic [15:0] sres;
    one  = 1;
    mask = (one << w) - one;
    half = one << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= half) ? ua - (one << w) : ua;
    sb   = (ub >= half) ? ub - (one << w) : ub;
    if (setup) begin
      full = ua + ub + longint'(ci);
      co   = (full > mask);
      sg   = sa + sb + longint'(ci);
    end else begin
      full = ua - ub - longint'(ci);
      co   = (ua < ub + longint'(ci));
      sg   = sa - sb - longint'(ci);
    end
    sres = 16'(full & mask);
    ov   = (sg > half - one) || (sg < -half);
    return {ov, co, sres};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Per-instance view for the model and compare processes (0 = 16-bit, 1 = 4-bit).
  logic        in_start[2], in_ci[2], in_setup[2];
  logic [15:0] in_a[2], in_b[2];
  logic [19:0] out_vec[2];
  assign in_start[0] = start16;  assign in_start[1] = start4;
  assign in_ci[0]    = ci16;     assign in_ci[1]    = ci4;
  assign in_setup[0] = setup16;  assign in_setup[1] = setup4;
  assign in_a[0]     = a16;      assign in_a[1]     = {12'h000, a4};
  assign in_b[0]     = b16;      assign in_b[1]     = {12'h000, b4};
  assign out_vec[0]  = {busy16, done16, co16, ov16, s16};
  assign out_vec[1]  = {busy4, done4, co4, ov4, 12'h000, s4};

  logic [17:0] pre[2];
  always_comb begin
    pre[0] = model_res(16, in_a[0], in_b[0], in_ci[0], in_setup[0]);
    pre[1] = model_res(4, in_a[1], in_b[1], in_ci[1], in_setup[1]);
  end

  // Cycle model: accept when idle, result appears N cycles later.
  logic        m_busy[2], m_done[2], m_co[2], m_ov[2];
  logic [15:0] m_s[2];
  logic [17:0] m_pend[2];
  int          m_left[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_co[k]   <= 1'b0;
        m_ov[k]   <= 1'b0;
        m_s[k]    <= 16'h0000;
        m_left[k] <= 0;
      end else begin
        m_done[k] <= 1'b0;
        if (m_busy[k] === 1'b1) begin
          if (m_left[k] == 1) begin
            m_busy[k] <= 1'b0;
            m_done[k] <= 1'b1;
            m_ov[k]   <= m_pend[k][17];
            m_co[k]   <= m_pend[k][16];
            m_s[k]    <= m_pend[k][15:0];
          end
          m_left[k] <= m_left[k] - 1;
        end else if (in_start[k]) begin
          m_pend[k] <= pre[k];
          m_busy[k] <= 1'b1;
          m_left[k] <= (k == 0) ? 4 : 1;
        end
      end
    end
  end

  // Compare every cycle: busy, done, co, ov, s against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("cycle_inst%0d", k), 32'(out_vec[k]),
              32'({m_busy[k], m_done[k], m_co[k], m_ov[k], m_s[k]}));
      end
    end
  end

  task automatic wait_done16(inout int cyc);
    while (done16 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Issue one 16-bit op from a negedge; returns at the done negedge.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic setup,
                       input logic [17:0] exp, input string nm);
    int cyc;
    a16 = a; b16 = b; ci16 = ci; setup16 = setup; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0;
    wait_done16(cyc);
    check({nm, "_latency"}, 32'(cyc), 32'd4);
    check({nm, "_result"}, 32'({ov16, co16, s16}), 32'(exp));
  endtask

  logic [15:0] vec_a[4] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
  logic [15:0] vec_b[4] = '{16'h8000, 16'hFFFF, 16'h0000, 16'hFFFF};
  logic        vec_c[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic        vec_m[4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int cyc, pulses;
    n_checks = 0; n_pass = 0; chk_en = 1'b0;
    rst_n = 1'b0;
    start16 = 1'b0; setup16 = 1'b0; ci16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
    start4 = 1'b0; setup4 = 1'b0; ci4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    repeat (3) @(negedge clk);
    check("reset16", 32'(out_vec[0]), 32'd0);
    check("reset4", 32'(out_vec[1]), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Pin the model with hand-computed values.
    check("model_add", 32'(model_res(16, 16'h1234, 16'h0FFF, 1'b0, 1'b1)), 32'({1'b0, 1'b0, 16'h2233}));
    check("model_sub", 32'(model_res(16, 16'h0005, 16'h0007, 1'b0, 1'b0)), 32'({1'b0, 1'b1, 16'hFFFE}));
    check("model_subov", 32'(model_res(16, 16'h8000, 16'h0001, 1'b0, 1'b0)), 32'({1'b1, 1'b0, 16'h7FFF}));
    check("model_w4", 32'(model_res(4, 16'h0007, 16'h0001, 1'b0, 1'b1)), 32'({1'b1, 1'b0, 16'h0008}));

    run16(16'h1234, 16'h0FFF, 1'b0, 1'b1, {1'b0, 1'b0, 16'h2233}, "add_basic");
    @(negedge clk);
    run16(16'h0005, 16'h0007, 1'b0, 1'b0, {1'b0, 1'b1, 16'hFFFE}, "sub_borrow");
    run16(16'h8000, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h7FFF}, "sub_ov");
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b0, 16'h8000}, "add_ov");
    run16(16'hFFFF, 16'h0000, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0000}, "add_carry");
    for (int i = 0; i < 4; i++)
      run16(vec_a[i], vec_b[i], vec_c[i], vec_m[i],
            model_res(16, vec_a[i], vec_b[i], vec_c[i], vec_m[i]), $sformatf("vec%0d", i));
    @(negedge clk);

    // Start during RUN is ignored; start in the done cycle is accepted.
    a16 = 16'h1234; b16 = 16'h0FFF; ci16 = 1'b0; setup16 = 1'b1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h1111; setup16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 2;
    wait_done16(cyc);
    check("ignore_latency", 32'(cyc), 32'd4);
    check("ignore_result", 32'({ov16, co16, s16}), 32'({1'b0, 1'b0, 16'h2233}));
    run16(16'h0005, 16'h0007, 1'b0, 1'b0, {1'b0, 1'b1, 16'hFFFE}, "back2back");

    // Reset in the middle of an operation aborts it.
    a16 = 16'h1234; b16 = 16'h0FFF; ci16 = 1'b0; setup16 = 1'b1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_state", 32'({busy16, done16, co16, ov16, s16}), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done16 === 1'b1) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);

    // Exhaustive 4-bit instance, back to back.
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++)
        for (int ai = 0; ai < 16; ai++)
          for (int bi = 0; bi < 16; bi++) begin
            a4 = 4'(ai); b4 = 4'(bi); ci4 = 1'(c); setup4 = 1'(m); start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            @(negedge clk);
            check("w4_done", 32'(done4), 32'd1);
            check("w4_result", 32'({ov4, co4, 12'h000, s4}),
                  32'(model_res(4, {12'h000, 4'(ai)}, {12'h000, 4'(bi)}, 1'(c), 1'(m))));
          end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
